// File: rtl/loader_write_fifo.sv
// Buffers loader byte writes and replays one per memory slot, held for the whole slot period.
// Latency: a pushed entry appears on mem_* at the first slot strobe at least one cycle after the push.
// Backpressure: none toward the loader; a push into a full FIFO without a concurrent slot is dropped and sets overflow.
module loader_write_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_wr,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     slot,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             full;
    logic             pop;
    logic             push;
    logic [ENT_W-1:0] head;

    assign full  = (level == LVL_W'(DEPTH));
    assign pop   = slot && (level != '0) && !flush;
    // A pop in the same cycle frees the slot the push would otherwise lack.
    assign push  = in_wr && !flush && (!full || pop);
    assign head  = store[rptr];
    assign empty = (level == '0) && !mem_we;

    always_ff @(posedge clk) begin
        if (push) begin
            store[wptr] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (in_wr && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // The request is held between slots so the SDRAM sees it for a full slot period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (flush) begin
            mem_we <= 1'b0;
        end else if (slot) begin
            mem_we <= pop;
            if (pop) begin
                mem_addr <= head[ENT_W-1:DATA_W];
                mem_data <= head[DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_loader_write_fifo.sv
// Randomized and directed scoreboard bench for loader_write_fifo with a queue-based reference model.
module tb_loader_write_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 22;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_wr;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          slot;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          empty;
    logic [2:0]    level;
    logic          overflow;

    always #5 clk = ~clk;

    loader_write_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_wr(in_wr),
        .in_addr(in_addr), .in_data(in_data), .slot(slot),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .empty(empty), .level(level), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: accepted-but-not-yet-emitted entries, plus expected status after the next edge.
    logic [AW+DW-1:0] exp_q[$];
    int               m_cnt = 0;
    bit               m_we  = 0;
    bit               m_ovf = 0;
    int               phase = 0;
    bit               slot_en = 1;
    bit               rnd_slot = 0;
    logic [AW+DW-1:0] last_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit fl);
        bit sl;
        bit pop;
        bit push;
        @(negedge clk);
        sl = slot_en && (phase % 4 == 0) && (!rnd_slot || $urandom_range(3) != 0);
        phase++;
        in_wr   = wr;
        in_addr = a;
        in_data = d;
        slot    = sl;
        flush   = fl;
        if (fl) begin
            m_cnt = 0;
            m_ovf = 0;
            m_we  = 0;
            exp_q.delete();
        end else begin
            pop  = sl && (m_cnt > 0);
            push = wr && ((m_cnt < DEPTH) || pop);
            if (wr && !push) m_ovf = 1;
            if (sl) m_we = pop;
            if (push) exp_q.push_back({a, d});
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0);
    endtask

    task automatic sync_slot();
        while (phase % 4 != 0) step(0, '0, '0, 0);
    endtask

    // Monitor: status every cycle; on each new presentation pop the scoreboard and compare.
    always @(posedge clk) begin
        logic [AW+DW-1:0] e;
        #1;
        if (!reset_n) begin
            last_out = '0;
        end else begin
            chk("level", 64'(level), 64'(m_cnt));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("empty", 64'(empty), 64'((m_cnt == 0) && !m_we));
            if (slot && mem_we && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
                    chk("out_data", 64'(mem_data), 64'(e[DW-1:0]));
                    last_out = e;
                end
            end else begin
                chk("hold_addr", 64'(mem_addr), 64'(last_out[AW+DW-1:DW]));
                chk("hold_data", 64'(mem_data), 64'(last_out[DW-1:0]));
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        flush   = 1'b0;
        in_wr   = 1'b0;
        in_addr = '0;
        in_data = '0;
        slot    = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write, then burst of three, with slots every 4 clk.
        slot_en = 1;
        sync_slot();
        idle(2);
        step(1, 22'h000010, 8'hA5, 0);
        idle(12);
        step(1, 22'h000100, 8'h11, 0);
        step(1, 22'h000101, 8'h22, 0);
        step(1, 22'h000102, 8'h33, 0);
        idle(20);

        // Overflow: five back-to-back writes with slots stopped, then drain.
        slot_en = 0;
        for (int i = 0; i < 5; i++) step(1, 22'(32'h300 + i), 8'(8'h40 + i), 0);
        idle(2);
        slot_en = 1;
        idle(24);

        // Clear overflow, fill to DEPTH, then push on a slot edge while full.
        step(0, '0, '0, 1);
        slot_en = 0;
        for (int i = 0; i < 4; i++) step(1, 22'(32'h400 + i), 8'(8'h50 + i), 0);
        slot_en = 1;
        sync_slot();
        step(1, 22'h000404, 8'h54, 0);
        idle(24);

        // Asynchronous reset mid-operation with level=2 and mem_we=1.
        slot_en = 0;
        for (int i = 0; i < 3; i++) step(1, 22'(32'h500 + i), 8'(8'h60 + i), 0);
        slot_en = 1;
        sync_slot();
        step(0, '0, '0, 0);
        slot_en = 0;
        step(0, '0, '0, 0);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_mem_we", 64'(mem_we), 64'(0));
        chk("arst_level", 64'(level), 64'(0));
        chk("arst_empty", 64'(empty), 64'(1));
        chk("arst_addr", 64'(mem_addr), 64'(0));
        chk("arst_data", 64'(mem_data), 64'(0));
        m_cnt = 0;
        m_we  = 0;
        m_ovf = 0;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // Flush with level=3, then a normal write afterwards.
        for (int i = 0; i < 3; i++) step(1, 22'(32'h600 + i), 8'(8'h70 + i), 0);
        step(1, 22'h0006FF, 8'hFF, 1);
        slot_en = 1;
        idle(3);
        step(1, 22'h000700, 8'h77, 0);
        idle(12);

        // Pointer wrap: ten writes paced one per slot.
        for (int i = 0; i < 10; i++) begin
            sync_slot();
            step(1, 22'(32'h200 + i), 8'(i), 0);
        end
        idle(12);

        // Random traffic: sparse writes, occasional bursts, skipped slots, rare flushes.
        rnd_slot = 1;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(99);
            if (r < 4) begin
                for (int k = 0; k < 3; k++) step(1, 22'($urandom), 8'($urandom), 0);
            end else if (r < 5) begin
                step($urandom_range(1) == 1, 22'($urandom), 8'($urandom), 1);
            end else if (r < 22) begin
                step(1, 22'($urandom), 8'($urandom), 0);
            end else begin
                step(0, '0, '0, 0);
            end
        end
        rnd_slot = 0;
        idle(40);
        chk("drained", 64'(exp_q.size()), 64'(0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
